// File: rtl/game_ctrl_if.sv
// Signal bundle between the game sequencer and the surrounding datapath:
// mouse/frame/bird/pipe status in, game state and scores out.
interface game_ctrl_if #(
   parameter int SCORE_W = 8
);
   logic               mouse_left;
   logic               frame_tick;
   logic [10:0]        bird_y;
   logic               collision;
   logic               pipe_passed;
   logic [1:0]         game_state;
   logic               game_rst;
   logic               play_en;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] high_score;

   modport master (
      output mouse_left, frame_tick, bird_y, collision, pipe_passed,
      input  game_state, game_rst, play_en, score, high_score
   );

   modport slave (
      input  mouse_left, frame_tick, bird_y, collision, pipe_passed,
      output game_state, game_rst, play_en, score, high_score
   );
endinterface

// File: rtl/game_ctrl.sv
// Flappy-bird game sequencer: IDLE/PLAY/OVER state machine, start pulse,
// death detection, saturating score and high score tracking.
module game_ctrl #(
   parameter int FLOOR_Y        = 700,
   parameter int CEIL_Y         = 0,
   parameter int BIRD_HEIGHT    = 100,
   parameter int HOLDOFF_FRAMES = 60,
   parameter int SCORE_W        = 8
) (
   input logic         clk,
   input logic         rst,
   game_ctrl_if.slave  bus
);
   localparam int HOLD_W = $clog2(HOLDOFF_FRAMES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLDOFF_FRAMES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                game_rst_q, game_rst_d;
   logic                play_en_q, play_en_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [SCORE_W-1:0]  high_score_q, high_score_d;
   logic [HOLD_W-1:0]   holdoff_q, holdoff_d;
   logic                mouse_prev_q;

   logic                click;
   logic                death;
   logic [11:0]         bird_bottom;

   // Bottom edge is formed at 12 bits so a large bird_y cannot wrap past the floor.
   assign bird_bottom = {1'b0, bus.bird_y} + 12'(BIRD_HEIGHT);
   assign death = bus.collision | (bus.bird_y <= 11'(CEIL_Y)) | (bird_bottom >= 12'(FLOOR_Y));
   assign click = bus.mouse_left & ~mouse_prev_q;

   always_comb begin
      state_d      = state_q;
      game_rst_d   = 1'b0;
      score_d      = score_q;
      high_score_d = high_score_q;
      holdoff_d    = holdoff_q;

      case (state_q)
         IDLE: begin
            if (click) begin
               state_d    = PLAY;
               score_d    = '0;
               game_rst_d = 1'b1;
            end
         end
         PLAY: begin
            // bird_y is still stale during the start-pulse cycle, so death waits one cycle.
            if (death && !game_rst_q) begin
               state_d   = OVER;
               holdoff_d = '0;
               if (score_q > high_score_q) begin
                  high_score_d = score_q;
               end
            end else if (bus.pipe_passed && (score_q != '1)) begin
               score_d = score_q + 1'b1;
            end
         end
         OVER: begin
            if (bus.frame_tick && (holdoff_q != HOLD_MAX)) begin
               holdoff_d = holdoff_q + 1'b1;
            end
            if (click && (holdoff_q == HOLD_MAX)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      play_en_d = (state_d == PLAY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         game_rst_q   <= 1'b0;
         play_en_q    <= 1'b0;
         score_q      <= '0;
         high_score_q <= '0;
         holdoff_q    <= '0;
         mouse_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         game_rst_q   <= game_rst_d;
         play_en_q    <= play_en_d;
         score_q      <= score_d;
         high_score_q <= high_score_d;
         holdoff_q    <= holdoff_d;
         mouse_prev_q <= bus.mouse_left;
      end
   end

   assign bus.game_state = state_q;
   assign bus.game_rst   = game_rst_q;
   assign bus.play_en    = play_en_q;
   assign bus.score      = score_q;
   assign bus.high_score = high_score_q;
endmodule
